// File: rtl/pwm_multi.sv
// pwm_multi -- multi-channel PWM generator with double-buffered period/duty.
//
// A single free-running frame counter is shared by CH output lanes. Each lane
// compares the counter against its own active duty and registers the result.
// New period/duty values are captured into shadow registers by `load` and
// moved into the active set only at a frame boundary (wrap), so a frame is
// never built from a mix of old and new settings. While `en` is low a load
// writes the active set directly.
//
// Build option:
//   PWM_CENTER_ALIGN_EN  defined  -> up/down (center-aligned) counter, frame of
//                                    2*period cycles, wrap on reaching 1 going down.
//                        undefined -> edge-aligned sawtooth, frame of period+1.
//
// Ports:
//   clk          clock, all state on rising edge
//   rst_n        asynchronous active-low reset
//   en           run enable; low parks the counter at 0 and drives outputs low
//   period [CW]  requested terminal count
//   duty [CH*CW] requested duty, channel i in bits [i*CW +: CW]
//   load         one-cycle strobe capturing period/duty
//   pwm_out[CH]  registered PWM outputs
//   pending      shadow values waiting for the next wrap
//   period_tick  one-cycle pulse in the first cycle (cnt==0) of a new frame

// Per-channel duty storage and comparator.
module pwm_multi_lane #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [CW-1:0] cnt,
  input  logic [CW-1:0] duty_in,
  input  logic          sh_wr,   // capture duty_in into shadow
  input  logic          act_new, // write duty_in straight into active
  input  logic          act_sh,  // promote shadow into active
  output logic          pwm
);
  logic [CW-1:0] sh_duty, act_duty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_duty  <= '0;
      act_duty <= '0;
      pwm      <= 1'b0;
    end else begin
      if (sh_wr)        sh_duty  <= duty_in;
      if (act_new)      act_duty <= duty_in;
      else if (act_sh)  act_duty <= sh_duty;
      // Full-width unsigned compare: duty 0 never fires, duty > period always fires.
      pwm <= en && (cnt < act_duty);
    end
  end
endmodule

module pwm_multi #(
  parameter int CH         = 4,
  parameter int CW         = 8,
  parameter int DEF_PERIOD = 99
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CW-1:0]    period,
  input  logic [CH*CW-1:0] duty,
  input  logic             load,
  output logic [CH-1:0]    pwm_out,
  output logic             pending,
  output logic             period_tick
);
  localparam logic [CW-1:0] DEF_P = CW'(DEF_PERIOD);
  localparam logic [CW-1:0] ONE   = CW'(1);

  logic [CH-1:0][CW-1:0] duty_v;
  logic [CW-1:0]         cnt, act_period, sh_period;
  logic                  wrap;
  logic                  sh_wr, act_new, act_sh;

  assign duty_v = duty;

  // Load routing. A load that lands on a wrap (or while stopped) goes straight
  // to active; the shadow is written too so it never holds stale values.
  assign sh_wr   = load;
  assign act_new = load && (!en || wrap);
  assign act_sh  = wrap && pending && !load;

`ifdef PWM_CENTER_ALIGN_EN
  logic dir_dn;

  // Period 0 wraps every cycle; period 1 wraps at the top (1) since there is
  // no down leg; otherwise wrap when reaching 1 on the way down.
  assign wrap = en && ((act_period == '0) ||
                       ((cnt == ONE) && (dir_dn || (act_period == ONE))));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      dir_dn <= 1'b0;
    end else if (!en || wrap) begin
      cnt    <= '0;
      dir_dn <= 1'b0;
    end else if (!dir_dn && (cnt == act_period)) begin
      cnt    <= cnt - ONE;
      dir_dn <= 1'b1;
    end else if (dir_dn) begin
      cnt    <= cnt - ONE;
    end else begin
      cnt    <= cnt + ONE;
    end
  end
`else
  assign wrap = en && (cnt == act_period);

  // cnt never exceeds act_period (period only changes at wrap or while
  // stopped with cnt=0), so the increment cannot overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            cnt <= '0;
    else if (!en || wrap)  cnt <= '0;
    else                   cnt <= cnt + ONE;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_period   <= DEF_P;
      act_period  <= DEF_P;
      pending     <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      period_tick <= wrap;
      if (sh_wr)        sh_period  <= period;
      if (act_new)      act_period <= period;
      else if (act_sh)  act_period <= sh_period;
      // A direct write while stopped supersedes anything still queued.
      if (!en) begin
        if (load) pending <= 1'b0;
      end else if (wrap) begin
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_lane
    pwm_multi_lane #(.CW(CW)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .cnt     (cnt),
      .duty_in (duty_v[g]),
      .sh_wr   (sh_wr),
      .act_new (act_new),
      .act_sh  (act_sh),
      .pwm     (pwm_out[g])
    );
  end
endmodule

// File: tb/tb_pwm_multi.sv
module tb_pwm_multi;
  localparam int CH = 4;
  localparam int CW = 8;
  localparam int DP = 99;

  logic             clk, rst_n, en, load;
  logic [CW-1:0]    period;
  logic [CH*CW-1:0] duty;
  logic [CH-1:0]    pwm_out;
  logic             pending, period_tick;

  pwm_multi #(.CH(CH), .CW(CW), .DEF_PERIOD(DP)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .period(period), .duty(duty),
    .load(load), .pwm_out(pwm_out), .pending(pending), .period_tick(period_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: position within the frame plus active/shadow settings.
  int            m_pos, act_p, sh_p;
  int            act_d[CH], sh_d[CH];
  bit            m_pend, exp_tick;
  logic [CH-1:0] exp_pwm;

  // Stimulus held between steps.
  bit s_en;
  int s_per;
  int s_duty[CH];

  // Observed-output tallies for frame-level checks.
  int hi_cnt[CH];
  int tick_cnt;

  task automatic m_reset();
    act_p = DP; sh_p = DP; m_pend = 0; m_pos = 0;
    exp_pwm = '0; exp_tick = 0;
    for (int i = 0; i < CH; i++) begin act_d[i] = 0; sh_d[i] = 0; end
  endtask

  // Advance the model across one rising edge with the current stimulus.
  task automatic model_upd(input bit ld);
    int c, flen;
    bit w;
`ifdef PWM_CENTER_ALIGN_EN
    c    = (m_pos <= act_p) ? m_pos : 2*act_p - m_pos;
    flen = (act_p == 0) ? 1 : 2*act_p;
`else
    c    = m_pos;
    flen = act_p + 1;
`endif
    w = s_en && (m_pos == flen - 1);
    for (int i = 0; i < CH; i++) exp_pwm[i] = s_en && (c < act_d[i]);
    exp_tick = w;
    if (ld && (!s_en || w)) begin
      act_p = s_per; sh_p = s_per; m_pend = 0;
      for (int i = 0; i < CH; i++) begin act_d[i] = s_duty[i]; sh_d[i] = s_duty[i]; end
    end else begin
      if (w && m_pend) begin
        act_p = sh_p;
        for (int i = 0; i < CH; i++) act_d[i] = sh_d[i];
      end
      if (w) m_pend = 0;
      if (ld) begin
        sh_p = s_per; m_pend = 1;
        for (int i = 0; i < CH; i++) sh_d[i] = s_duty[i];
      end
    end
    m_pos = (!s_en || w) ? 0 : m_pos + 1;
  endtask

  // One cycle: check outputs at the falling edge, then drive next inputs.
  task automatic step(input bit ld);
    @(negedge clk);
    chk("pwm",  pwm_out, exp_pwm);
    chk("pend", pending, m_pend);
    chk("tick", period_tick, exp_tick);
    for (int i = 0; i < CH; i++) if (pwm_out[i]) hi_cnt[i]++;
    if (period_tick) tick_cnt++;
    en     = s_en;
    load   = ld;
    period = CW'(s_per);
    for (int i = 0; i < CH; i++) duty[i*CW +: CW] = CW'(s_duty[i]);
    model_upd(ld);
  endtask

  task automatic clr_tally();
    for (int i = 0; i < CH; i++) hi_cnt[i] = 0;
    tick_cnt = 0;
  endtask

  task automatic wait_pos(input int target);
    bit hit = 0;
    for (int k = 0; k < 600 && !hit; k++) begin
      if (m_pos == target) hit = 1;
      else step(0);
    end
    chk("wait_pos", hit, 1);
  endtask

  // Asynchronous reset in the middle of a cycle, released on a falling edge.
  task automatic mid_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_pwm",  pwm_out, 0);
    chk("rst_pend", pending, 0);
    chk("rst_tick", period_tick, 0);
    m_reset();
    @(negedge clk);
    load  = 1'b0;
    rst_n = 1'b1;
    model_upd(0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; load = 1'b0; period = '0; duty = '0;
    s_en = 0; s_per = 0;
    for (int i = 0; i < CH; i++) s_duty[i] = 0;
    m_reset();
    clr_tally();
    repeat (2) @(negedge clk);
    chk("rst_pwm",  pwm_out, 0);
    chk("rst_pend", pending, 0);
    chk("rst_tick", period_tick, 0);
    rst_n = 1'b1;
    model_upd(0);

`ifdef PWM_CENTER_ALIGN_EN
    s_per = 10; s_duty[0] = 4; s_duty[1] = 0; s_duty[2] = 255; s_duty[3] = 10;
    step(1);
    s_en = 1;
    repeat (5) step(0);
    clr_tally();
    repeat (40) step(0);
    chk("c_hi0",  hi_cnt[0], 14);
    chk("c_hi2",  hi_cnt[2], 40);
    chk("c_tick", tick_cnt, 2);
`else
    // Direct load while stopped, then run: 20/100, constant low/high, 50/100.
    s_per = 99; s_duty[0] = 20; s_duty[1] = 0; s_duty[2] = 255; s_duty[3] = 50;
    step(1);
    s_en = 1;
    repeat (5) step(0);
    clr_tally();
    repeat (200) step(0);
    chk("hi0_20",  hi_cnt[0], 40);
    chk("hi1_0",   hi_cnt[1], 0);
    chk("hi2_255", hi_cnt[2], 200);
    chk("hi3_50",  hi_cnt[3], 100);
    chk("tick100", tick_cnt, 2);

    // Mid-frame load: pending until wrap, new width from next frame.
    wait_pos(50);
    s_duty[0] = 60;
    step(1);
    step(0);
    chk("pend36", pending, 1);
    wait_pos(0);
    step(0);
    clr_tally();
    repeat (100) step(0);
    chk("hi0_60", hi_cnt[0], 60);

    // Load on the wrap cycle applies immediately; pending stays low.
    wait_pos(99);
    s_duty[0] = 30;
    step(1);
    step(0);
    chk("pend37", pending, 0);
    clr_tally();
    repeat (100) step(0);
    chk("hi0_30", hi_cnt[0], 30);

    // Reset with a load pending: defaults return, pending dropped.
    wait_pos(30);
    s_duty[0] = 77;
    step(1);
    wait_pos(40);
    chk("pend38", pending, 1);
    mid_reset();
    clr_tally();
    repeat (210) step(0);
    chk("hi0_def", hi_cnt[0], 0);
    chk("tick_def", tick_cnt, 2);
`endif

    // Randomized run against the model.
    for (int k = 0; k < 3000; k++) begin
      bit ld;
      if ($urandom_range(0, 39) == 0) s_en = !s_en;
      if ($urandom_range(0, 499) == 0) begin
        mid_reset();
      end else begin
        ld = ($urandom_range(0, 9) == 0);
        if (ld) begin
          s_per = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255))
                                              : int'($urandom_range(0, 12));
          for (int i = 0; i < CH; i++)
            s_duty[i] = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 255))
                                                    : int'($urandom_range(0, 14));
        end
        step(ld);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/pwm_multi.md
PWM_MULTI -- requirements
Module: pwm_multi

Interface
REQ-001 Parameter CH, default 4, number of independent PWM channels (1..16).
REQ-002 Parameter CW, default 8, counter/period/duty width in bits (4..16).
REQ-003 Parameter DEF_PERIOD, default 99, active period value after reset (100-cycle frame).
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 en  input  1  run enable; low holds counter at 0 and forces outputs low.
REQ-007 period  input  CW  requested terminal count; frame length is period+1 cycles (edge mode).
REQ-008 duty  input  CH*CW  requested duty per channel, channel i in bits [i*CW +: CW].
REQ-009 load  input  1  single-cycle strobe capturing period and duty into shadow registers.
REQ-010 pwm_out  output  CH  registered PWM outputs.
REQ-011 pending  output  1  high while shadow values await application at the next frame boundary.
REQ-012 period_tick  output  1  one-cycle pulse marking the first cycle of each new frame.

Function
REQ-013 Counter cnt (CW bits) SHALL start at 0 and increment by 1 per clk while en=1.
REQ-014 Edge mode: when cnt == active period and en=1 (wrap), cnt SHALL return to 0 the next cycle.
REQ-015 pwm_out[i] SHALL be registered as en && (cnt < active duty[i]), giving one cycle latency from cnt.
REQ-016 Active duty 0 SHALL give constant low; active duty > active period SHALL give constant high.
REQ-017 Active period 0 SHALL hold cnt at 0, assert wrap every cycle, and drive a channel high iff its duty is non-zero.
REQ-018 Comparisons SHALL be unsigned at full CW width, with no truncation or overflow on cnt.
REQ-019 load with en=1 SHALL capture period/duty into shadow and set pending=1 the next cycle.
REQ-020 At wrap, shadow SHALL be copied to active and pending cleared, so a frame never mixes old and new values.
REQ-021 A later load before wrap SHALL overwrite shadow; only the last captured values apply.
REQ-022 load coincident with wrap SHALL apply the newly presented values at that wrap, leaving pending=0.
REQ-023 load with en=0 SHALL write active directly; pending SHALL stay 0.
REQ-024 en falling SHALL clear cnt to 0 and pwm_out to 0 next cycle; active, shadow and pending SHALL be retained.
REQ-025 en rising SHALL start counting from cnt=0; the shadow-to-active copy SHALL occur at the first wrap.
REQ-026 period_tick SHALL be registered high for exactly the cycle in which cnt==0 following a wrap.

Reset
REQ-027 rst_n low SHALL asynchronously set cnt=0, pwm_out=0, pending=0, period_tick=0, and direction=up.
REQ-028 Reset SHALL load active and shadow period with DEF_PERIOD, and all active and shadow duties with 0.
REQ-029 Reset deasserted mid-frame SHALL discard any pending load; operation SHALL restart from cnt=0.

Configuration
REQ-030 Macro PWM_CENTER_ALIGN_EN defined: cnt SHALL count up from 0 to active period, then down to 1, with a frame of 2*period cycles.
REQ-031 With PWM_CENTER_ALIGN_EN, wrap (shadow apply, period_tick) SHALL occur when cnt reaches 1 counting down, and cnt SHALL be 0 on the next cycle.
REQ-032 With PWM_CENTER_ALIGN_EN, the output rule of REQ-015 SHALL be unchanged, and active period 0 SHALL behave as REQ-017.
REQ-033 Without PWM_CENTER_ALIGN_EN: edge-aligned sawtooth only; no direction register is synthesised.

Verification
REQ-034 CW=8, CH=4, period=99, duty0=20, load, en=1 -> pwm_out[0] high 20 of every 100 cycles; period_tick every 100 cycles.
REQ-035 duty1=0, duty2=255, period=99 -> pwm_out[1] constant 0, pwm_out[2] constant 1 while en=1.
REQ-036 load duty0=60 at cnt=50 -> pulse width stays 20 this frame, pending=1 until wrap, width 60 from next frame.
REQ-037 load asserted in the wrap cycle (cnt=99) -> new values active from cnt=0, pending never asserts.
REQ-038 rst_n low at cnt=40 with pending=1 -> pwm_out=0, pending=0 immediately; after release, period=99 and duties=0.
REQ-039 PWM_CENTER_ALIGN_EN, period=10, duty0=4 -> frame 20 cycles, pwm_out[0] high 7 cycles per frame, period_tick every 20.
